// File: rtl/alu_shifting_pkg.sv
// Shared types and sizing for the alu_shifting barrel shifter/rotator.
// Operation codes come from the select decoder; fill modes steer the barrel stages.
package alu_shifting_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_SHR,
    OP_SHRA,
    OP_SHL,
    OP_ROR,
    OP_ROL,
    OP_ILLEGAL
  } op_e;

  typedef enum logic [1:0] {
    FILL_ZERO,
    FILL_SIGN,
    FILL_WRAP
  } fill_e;

endpackage

// File: rtl/alu_shifting_if.sv
// Operand, select and result bundle for alu_shifting.
// The master drives operands and selects; the slave returns results.
interface alu_shifting_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             SHR;
  logic             SHRA;
  logic             SHL;
  logic             ROR;
  logic             ROL;
  logic [WIDTH-1:0] c;
  logic             err;
  logic [WIDTH-1:0] c_q;
  logic             err_q;

  modport master (
    output a, b, SHR, SHRA, SHL, ROR, ROL,
    input  c, err, c_q, err_q
  );

  modport slave (
    input  a, b, SHR, SHRA, SHL, ROR, ROL,
    output c, err, c_q, err_q
  );
endinterface

// File: rtl/alu_shifting_barrel_stage.sv
// One fixed-distance right-shift stage of the barrel core.
// Vacated MSBs come from zero, a replicated sign bit, or the bits shifted out.
module barrel_stage
  import alu_shifting_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  fill_e            fill,
  input  logic             sign,
  output logic [WIDTH-1:0] dout
);

  logic [DIST-1:0] src;

  always_comb begin
    src = '0;
    unique case (fill)
      FILL_ZERO: src = '0;
      FILL_SIGN: src = {DIST{sign}};
      FILL_WRAP: src = din[DIST-1:0];
      default:   src = '0;
    endcase
    dout = en ? {src, din[WIDTH-1:DIST]} : din;
  end

endmodule

// File: rtl/alu_shifting.sv
// Combinational shift/rotate unit with registered copies of the result and error flag.
// Left operations reuse the right-shift core by bit-reversing its input and output.
module alu_shifting
  import alu_shifting_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic         clk,
  input logic         clr_n,
  alu_shifting_if.slave bus
);

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  op_e              op;
  fill_e            fill;
  logic             left;
  logic [SHW-1:0]   n;
  logic [WIDTH-1:0] chain [0:SHW];
  logic [WIDTH-1:0] shifted;
  logic             unused_b;

  assign n        = bus.b[SHW-1:0];
  assign unused_b = ^bus.b[WIDTH-1:SHW];

  // Decode: exactly one select picks an operation, several are illegal.
  always_comb begin
    op = OP_NONE;
    if ($countones({bus.SHR, bus.SHRA, bus.SHL, bus.ROR, bus.ROL}) > 1) op = OP_ILLEGAL;
    else if (bus.SHR)  op = OP_SHR;
    else if (bus.SHRA) op = OP_SHRA;
    else if (bus.SHL)  op = OP_SHL;
    else if (bus.ROR)  op = OP_ROR;
    else if (bus.ROL)  op = OP_ROL;
  end

  always_comb begin
    fill = FILL_ZERO;
    if (op == OP_SHRA) fill = FILL_SIGN;
    else if (op == OP_ROR || op == OP_ROL) fill = FILL_WRAP;
  end

  assign left     = (op == OP_SHL) || (op == OP_ROL);
  assign chain[0] = left ? bitrev(bus.a) : bus.a;

  // Barrel core: stages of 16, 8, 4, 2, 1 controlled by n from MSB to LSB.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << (SHW - 1 - k))
    ) u_stage (
      .din  (chain[k]),
      .en   (n[SHW-1-k]),
      .fill (fill),
      .sign (bus.a[WIDTH-1]),
      .dout (chain[k+1])
    );
  end

  assign shifted = left ? bitrev(chain[SHW]) : chain[SHW];

  always_comb begin
    bus.err = (op == OP_ILLEGAL);
    bus.c   = (op == OP_NONE || op == OP_ILLEGAL) ? '0 : shifted;
  end

  // Output register: the only state in the block.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bus.c_q   <= '0;
      bus.err_q <= 1'b0;
    end else begin
      bus.c_q   <= bus.c;
      bus.err_q <= bus.err;
    end
  end

endmodule

// File: tb/tb_alu_shifting.sv
// Directed-vector bench for alu_shifting: shifts, rotates, decode errors,
// the output register and asynchronous reset behaviour.
module tb_alu_shifting;

  logic clk;
  logic clr_n;
  int   n_tests;
  int   n_fail;

  alu_shifting_if #(.WIDTH(32)) bus ();

  alu_shifting #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel order: {SHR, SHRA, SHL, ROR, ROL}
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sel);
    bus.a    = a;
    bus.b    = b;
    bus.SHR  = sel[4];
    bus.SHRA = sel[3];
    bus.SHL  = sel[2];
    bus.ROR  = sel[1];
    bus.ROL  = sel[0];
  endtask

  task automatic test_reset();
    drive(32'h1234_5678, 32'd4, 5'b00100);
    clr_n = 1'b0;
    #1;
    n_tests++;
    if (bus.c_q !== 32'h0 || bus.err_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: c_q=%h err_q=%b required c_q=0 err_q=0", bus.c_q, bus.err_q);
    end
    n_tests++;
    if (bus.c !== 32'h2345_6780) begin
      n_fail++;
      $display("FAIL reset_comb: c=%h required 23456780", bus.c);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.c_q !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold: c_q=%h required 0", bus.c_q);
    end
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_shr_sweep();
    logic [31:0] exp;
    for (int i = 0; i < 32; i++) begin
      drive(32'h8000_0001, i, 5'b10000);
      exp = 32'h8000_0001 >> i;
      #1;
      n_tests++;
      if (bus.c !== exp) begin
        n_fail++;
        $display("FAIL shr_sweep b=%0d: c=%h required %h", i, bus.c, exp);
      end
    end
    n_tests++;
    if (bus.c !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL shr_b31: c=%h required 00000001", bus.c);
    end
    drive(32'h8000_0000, 32'd33, 5'b10000);
    #1;
    n_tests++;
    if (bus.c !== 32'h4000_0000) begin
      n_fail++;
      $display("FAIL shr_b33: c=%h required 40000000", bus.c);
    end
  endtask

  task automatic test_shra();
    drive(32'h8000_0000, 32'd4, 5'b01000);
    #1;
    n_tests++;
    if (bus.c !== 32'hF800_0000) begin
      n_fail++;
      $display("FAIL shra_neg: c=%h required f8000000", bus.c);
    end
    drive(32'h8000_0000, 32'd4, 5'b10000);
    #1;
    n_tests++;
    if (bus.c !== 32'h0800_0000) begin
      n_fail++;
      $display("FAIL shr_vs_shra: c=%h required 08000000", bus.c);
    end
    drive(32'h7000_0000, 32'd4, 5'b01000);
    #1;
    n_tests++;
    if (bus.c !== 32'h0700_0000) begin
      n_fail++;
      $display("FAIL shra_pos: c=%h required 07000000", bus.c);
    end
    drive(32'h8765_4321, 32'd31, 5'b01000);
    #1;
    n_tests++;
    if (bus.c !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL shra_b31: c=%h required ffffffff", bus.c);
    end
  endtask

  task automatic test_shl();
    drive(32'h0000_0001, 32'd31, 5'b00100);
    #1;
    n_tests++;
    if (bus.c !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL shl_b31: c=%h required 80000000", bus.c);
    end
    drive(32'h0000_0001, 32'd32, 5'b00100);
    #1;
    n_tests++;
    if (bus.c !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL shl_b32: c=%h required 00000001", bus.c);
    end
    drive(32'h1234_5678, 32'd12, 5'b00100);
    #1;
    n_tests++;
    if (bus.c !== 32'h4567_8000) begin
      n_fail++;
      $display("FAIL shl_b12: c=%h required 45678000", bus.c);
    end
  endtask

  task automatic test_rotate();
    drive(32'h0000_0001, 32'd1, 5'b00010);
    #1;
    n_tests++;
    if (bus.c !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL ror_b1: c=%h required 80000000", bus.c);
    end
    drive(32'h8000_0001, 32'd4, 5'b00001);
    #1;
    n_tests++;
    if (bus.c !== 32'h0000_0018) begin
      n_fail++;
      $display("FAIL rol_b4: c=%h required 00000018", bus.c);
    end
    drive(32'h1234_5678, 32'd8, 5'b00010);
    #1;
    n_tests++;
    if (bus.c !== 32'h7812_3456) begin
      n_fail++;
      $display("FAIL ror_b8: c=%h required 78123456", bus.c);
    end
    drive(32'h1234_5678, 32'd8, 5'b00001);
    #1;
    n_tests++;
    if (bus.c !== 32'h3456_7812) begin
      n_fail++;
      $display("FAIL rol_b8: c=%h required 34567812", bus.c);
    end
    drive(32'h1234_5678, 32'd20, 5'b00010);
    #1;
    n_tests++;
    if (bus.c !== 32'h4567_8123) begin
      n_fail++;
      $display("FAIL ror_b20: c=%h required 45678123", bus.c);
    end
  endtask

  task automatic test_n_zero();
    logic [4:0] sels [5];
    sels = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    for (int i = 0; i < 5; i++) begin
      drive(32'hDEAD_BEEF, 32'h0000_0020, sels[i]);
      #1;
      n_tests++;
      if (bus.c !== 32'hDEAD_BEEF || bus.err !== 1'b0) begin
        n_fail++;
        $display("FAIL n_zero sel=%b: c=%h err=%b required deadbeef err=0", sels[i], bus.c, bus.err);
      end
    end
  endtask

  task automatic test_select_errors();
    drive(32'hFFFF_FFFF, 32'd3, 5'b00000);
    #1;
    n_tests++;
    if (bus.c !== 32'h0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL no_select: c=%h err=%b required c=0 err=0", bus.c, bus.err);
    end
    @(negedge clk);
    drive(32'hFFFF_FFFF, 32'd3, 5'b10001);
    #1;
    n_tests++;
    if (bus.c !== 32'h0 || bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL shr_rol: c=%h err=%b required c=0 err=1", bus.c, bus.err);
    end
    n_tests++;
    if (bus.err_q !== 1'b0) begin
      n_fail++;
      $display("FAIL err_q_before_edge: err_q=%b required 0", bus.err_q);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.err_q !== 1'b1 || bus.c_q !== 32'h0) begin
      n_fail++;
      $display("FAIL err_q_after_edge: err_q=%b c_q=%h required err_q=1 c_q=0", bus.err_q, bus.c_q);
    end
    drive(32'hFFFF_FFFF, 32'd3, 5'b11111);
    #1;
    n_tests++;
    if (bus.c !== 32'h0 || bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL all_selects: c=%h err=%b required c=0 err=1", bus.c, bus.err);
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    drive(32'h0000_00F0, 32'd4, 5'b10000);
    #1;
    n_tests++;
    if (bus.c !== 32'h0000_000F || bus.c_q !== 32'h0) begin
      n_fail++;
      $display("FAIL reg_before: c=%h c_q=%h required c=0000000f c_q=0", bus.c, bus.c_q);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.c_q !== 32'h0000_000F || bus.err_q !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_capture: c_q=%h err_q=%b required 0000000f err_q=0", bus.c_q, bus.err_q);
    end
    drive(32'h0000_00F0, 32'd4, 5'b00100);
    @(posedge clk); #1;
    n_tests++;
    if (bus.c_q !== 32'h0000_0F00) begin
      n_fail++;
      $display("FAIL back_to_back: c_q=%h required 00000f00", bus.c_q);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(32'h0000_0001, 32'd4, 5'b00100);
    @(posedge clk); #1;
    n_tests++;
    if (bus.c_q !== 32'h0000_0010) begin
      n_fail++;
      $display("FAIL pre_reset_capture: c_q=%h required 00000010", bus.c_q);
    end
    #1;
    clr_n = 1'b0;
    #1;
    n_tests++;
    if (bus.c_q !== 32'h0 || bus.err_q !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: c_q=%h err_q=%b required c_q=0 err_q=0", bus.c_q, bus.err_q);
    end
    n_tests++;
    if (bus.c !== 32'h0000_0010) begin
      n_fail++;
      $display("FAIL comb_in_reset: c=%h required 00000010", bus.c);
    end
    bus.a = 32'h0000_0002;
    #1;
    n_tests++;
    if (bus.c !== 32'h0000_0020 || bus.c_q !== 32'h0) begin
      n_fail++;
      $display("FAIL track_in_reset: c=%h c_q=%h required c=00000020 c_q=0", bus.c, bus.c_q);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.c_q !== 32'h0) begin
      n_fail++;
      $display("FAIL edge_in_reset: c_q=%h required 0", bus.c_q);
    end
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    n_tests++;
    if (bus.c_q !== 32'h0) begin
      n_fail++;
      $display("FAIL release_no_edge: c_q=%h required 0", bus.c_q);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.c_q !== 32'h0000_0020) begin
      n_fail++;
      $display("FAIL release_capture: c_q=%h required 00000020", bus.c_q);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clr_n   = 1'b1;
    drive(32'h0, 32'h0, 5'b00000);
    test_reset();
    test_shr_sweep();
    test_shra();
    test_shl();
    test_rotate();
    test_n_zero();
    test_select_errors();
    test_registered();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
